// File: rtl/key_echo_tx.sv
// Echoes each newly pressed direction key (ASCII '1'..'9') as one 8N1 UART frame.
// Optional KEY_ECHO_CRLF_EN: every key byte is followed by 0x0D, 0x0A frames.
module key_echo_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    output logic       tx,
    output logic       busy,
    output logic       sent
);

    // state  | meaning
    // IDLE   | line high, waiting for a key change
    // START  | start bit (tx=0) of a key byte
    // DATA   | 8 data bits, LSB first
    // STOP   | stop bit (tx=1); frame boundary decisions taken on its last cycle
    // SUFFIX | start bit of a CR or LF suffix frame (CRLF build only)
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef KEY_ECHO_CRLF_EN
        , SUFFIX
`endif
    } state_t;

    localparam logic [15:0] LP_RELOAD = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_last_key;
    logic [7:0]  r_pend;
    logic        r_pend_vld;
    logic        r_tx;
`ifdef KEY_ECHO_CRLF_EN
    logic [1:0]  r_phase;
    logic [1:0]  w_phase_nxt;
`endif

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  w_shift_nxt;
    logic [7:0]  w_last_nxt;
    logic [7:0]  w_pend_nxt;
    logic        w_pend_vld_nxt;
    logic        w_tx_nxt;

    logic        w_key_valid;
    logic        w_change;
    logic        w_same;
    logic        w_tick;
    logic        w_nxt_vld;
    logic [7:0]  w_nxt_key;
    logic        w_end;
    logic        w_launch;
    logic [7:0]  w_launch_key;

    assign w_key_valid = (key_in >= 8'h31) && (key_in <= 8'h39);
    assign w_change    = w_key_valid && (key_in != r_last_key);
    assign w_same      = w_key_valid && (key_in == r_last_key);
    assign w_tick      = (r_cnt == 16'd0);

    // A change seen on the final stop cycle beats the stored pending value;
    // a return to the in-flight code cancels whatever was pending.
    assign w_nxt_vld = w_change || (r_pend_vld && !w_key_valid);
    assign w_nxt_key = w_change ? key_in : r_pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_last_key <= 8'h00;
            r_pend     <= 8'h00;
            r_pend_vld <= 1'b0;
            r_tx       <= 1'b1;
`ifdef KEY_ECHO_CRLF_EN
            r_phase    <= 2'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_last_key <= w_last_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_tx       <= w_tx_nxt;
`ifdef KEY_ECHO_CRLF_EN
            r_phase    <= w_phase_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_last_nxt     = r_last_key;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_tx_nxt       = r_tx;
`ifdef KEY_ECHO_CRLF_EN
        w_phase_nxt    = r_phase;
`endif
        w_end          = 1'b0;
        w_launch       = 1'b0;
        w_launch_key   = key_in;

        if (r_state != IDLE) begin
            w_cnt_nxt = w_tick ? LP_RELOAD : (r_cnt - 16'd1);
            if (w_change) begin
                w_pend_nxt     = key_in;
                w_pend_vld_nxt = 1'b1;
            end else if (w_same) begin
                w_pend_vld_nxt = 1'b0;
            end
        end

        case (r_state)
            IDLE: begin
                if (w_change) begin
                    w_launch     = 1'b1;
                    w_launch_key = key_in;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                    w_idx_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                        w_idx_nxt   = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
`ifdef KEY_ECHO_CRLF_EN
                    if (r_phase != 2'd2) begin
                        w_state_nxt = SUFFIX;
                        w_shift_nxt = (r_phase == 2'd0) ? 8'h0D : 8'h0A;
                        w_tx_nxt    = 1'b0;
                        w_phase_nxt = r_phase + 2'd1;
                    end else begin
                        w_end = 1'b1;
                    end
`else
                    w_end = 1'b1;
`endif
                end
            end
`ifdef KEY_ECHO_CRLF_EN
            SUFFIX: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                    w_idx_nxt   = 3'd0;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        if (w_end) begin
            if (w_nxt_vld) begin
                w_launch     = 1'b1;
                w_launch_key = w_nxt_key;
            end else begin
                w_state_nxt    = IDLE;
                w_tx_nxt       = 1'b1;
                w_cnt_nxt      = 16'd0;
                w_idx_nxt      = 3'd0;
                w_pend_vld_nxt = 1'b0;
            end
        end

        // New key frames start with the line already low on the next cycle.
        if (w_launch) begin
            w_state_nxt    = START;
            w_cnt_nxt      = LP_RELOAD;
            w_idx_nxt      = 3'd0;
            w_shift_nxt    = w_launch_key;
            w_last_nxt     = w_launch_key;
            w_tx_nxt       = 1'b0;
            w_pend_vld_nxt = 1'b0;
`ifdef KEY_ECHO_CRLF_EN
            w_phase_nxt    = 2'd0;
`endif
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != IDLE);
`ifdef KEY_ECHO_CRLF_EN
    assign sent = (r_state == STOP) && w_tick && (r_phase == 2'd0);
`else
    assign sent = (r_state == STOP) && w_tick;
`endif

endmodule

// File: tb/tb_key_echo_tx.sv
// Scoreboard bench for key_echo_tx: expected bytes queued at stimulus time,
// popped when the line monitor decodes a complete frame.
module tb_key_echo_tx;

    localparam int CPB = 4;
`ifdef KEY_ECHO_CRLF_EN
    localparam int FL = 120;
`else
    localparam int FL = 40;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic [7:0] key_in = 8'h34;
    logic       tx;
    logic       busy;
    logic       sent;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    key_echo_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .key_in (key_in),
        .tx     (tx),
        .busy   (busy),
        .sent   (sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_key(input logic [7:0] b);
        return (b >= 8'h31) && (b <= 8'h39);
    endfunction

    task automatic push_exp(input logic [7:0] k);
        exp_q.push_back(k);
`ifdef KEY_ECHO_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Line monitor: 40 samples per frame, one per clk, taken on the falling edge.
    logic m_in_frame = 1'b0;
    int   m_idx      = 0;
    logic m_smp [40];

    always @(negedge clk) begin : mon
        logic [7:0] d;
        int         bad;
        logic       exp_sent;
        if (!rst) begin
            m_in_frame = 1'b0;
            m_idx      = 0;
        end else begin
            if (!m_in_frame) begin
                if (tx === 1'b0) begin
                    m_in_frame = 1'b1;
                    m_idx      = 0;
                    m_smp[0]   = tx;
                end
            end else begin
                m_idx++;
                m_smp[m_idx] = tx;
            end
            exp_sent = m_in_frame && (m_idx == 39) && (exp_q.size() > 0) && is_key(exp_q[0]);
            check("sent", {31'd0, sent}, {31'd0, exp_sent});
            if (m_in_frame && m_idx == 39) begin
                bad = 0;
                for (int b = 0; b < 10; b++)
                    for (int s = 1; s < 4; s++)
                        if (m_smp[4*b+s] !== m_smp[4*b]) bad++;
                check("frame_bits_stable", bad, 0);
                check("frame_stop", {31'd0, m_smp[36]}, 32'd1);
                for (int b = 0; b < 8; b++) d[b] = m_smp[4*(b+1)];
                if (exp_q.size() == 0) check("frame_unexpected", {24'd0, d}, 32'h1FF);
                else                   check("frame_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
                m_in_frame = 1'b0;
            end
        end
    end

    // Drive k0 at a falling edge, optionally change key_in at frame clk t1/t2,
    // and measure how many clks busy stays high after the launch edge.
    task automatic track(input logic [7:0] k0, input int t1, input logic [7:0] k1,
                         input int t2, input logic [7:0] k2, input int exp_len, input string tag);
        int n;
        key_in = k0;
        @(posedge clk);
        #1;
        check({tag, "_lat_tx"}, {31'd0, tx}, 32'd0);
        check({tag, "_lat_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (t1 != 0 && n == t1) key_in = k1;
            if (t2 != 0 && n == t2) key_in = k2;
            if (n > 2000) break;
        end
        check({tag, "_len"}, n, exp_len);
    endtask

    task automatic quiet(input int cycles, input string tag);
        int act;
        act = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1 || sent !== 1'b0) act++;
        end
        check(tag, act, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] bad_codes [4];
        bad_codes = '{8'h41, 8'h00, 8'h30, 8'h3A};

        repeat (3) @(negedge clk);
        check("rst_tx",   {31'd0, tx},   32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sent", {31'd0, sent}, 32'd0);

        rst = 1'b1;
        push_exp(8'h34);
        track(8'h34, 0, 8'h00, 0, 8'h00, FL, "post_rst");

        quiet(200, "hold_same_key");

        foreach (bad_codes[i]) begin
            key_in = bad_codes[i];
            quiet(6, "invalid_code");
        end
        push_exp(8'h31);
        track(8'h31, 0, 8'h00, 0, 8'h00, FL, "k31");

        push_exp(8'h38);
        push_exp(8'h32);
        track(8'h38, 10, 8'h36, 20, 8'h32, 2*FL, "pend_latest");
        quiet(30, "after_pend");

        push_exp(8'h35);
        track(8'h35, 10, 8'h37, 20, 8'h35, FL, "pend_discard");
        quiet(30, "after_discard");

        push_exp(8'h33);
        push_exp(8'h36);
        track(8'h33, FL, 8'h36, 0, 8'h00, 2*FL, "final_stop_change");
        quiet(20, "after_b2b");

        key_in = 8'h39;
        @(posedge clk);
        repeat (15) @(negedge clk);
        check("pre_abort_tx", {31'd0, tx}, 32'd0);
        #1 rst = 1'b0;
        #1;
        check("abort_tx",   {31'd0, tx},   32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sent", {31'd0, sent}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push_exp(8'h39);
        track(8'h39, 0, 8'h00, 0, 8'h00, FL, "after_abort");

        quiet(20, "final_idle");
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_echo_tx.md
KEY_ECHO_TX -- requirements
Module: key_echo_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-004 key_in  input  8  ASCII direction code from the moving-key driver, sampled every clk.
REQ-005 tx  output  1  UART serial line, 8N1, idle high.
REQ-006 busy  output  1  high while any frame is in flight.
REQ-007 sent  output  1  one-cycle pulse on the last stop-bit cycle of each key byte.

Function
REQ-008 Valid codes SHALL be 0x31..0x39 inclusive; any other key_in value SHALL be ignored and SHALL NOT alter internal state.
REQ-009 Block SHALL hold last_key (8 bit), the last code accepted for transmission.
REQ-010 A change SHALL be a valid key_in differing from last_key; key_in equal to last_key SHALL never cause a transmission.
REQ-011 FSM states: IDLE, START, DATA, STOP; with CRLF feature also SUFFIX (see REQ-024).
REQ-012 IDLE: on a change, next cycle SHALL load shift register with key_in, update last_key, enter START, assert busy.
REQ-013 START: tx=0 for exactly CLKS_PER_BIT cycles; DATA: 8 bits LSB first, each exactly CLKS_PER_BIT cycles; STOP: tx=1 for exactly CLKS_PER_BIT cycles.
REQ-014 Bit timing SHALL use a baud counter reloaded at every bit boundary; bit index counter 0..7 in DATA.
REQ-015 Latency from key_in change (sampled edge) to tx falling edge SHALL be exactly 1 clk.
REQ-016 Changes while busy SHALL be captured in a one-deep pending register; a later change while busy SHALL overwrite pending (latest value wins).
REQ-017 A pending value equal to the code currently in flight SHALL be discarded (no duplicate send).
REQ-018 At end of STOP (or end of suffix when enabled), if pending is valid the FSM SHALL go directly to START with pending loaded and busy held high; otherwise IDLE and busy low on the next cycle.
REQ-019 Change coinciding with the final STOP cycle SHALL be treated as pending and sent back-to-back with no idle bit.
REQ-020 sent SHALL pulse once per key byte, on the final STOP cycle of that byte only.
REQ-021 tx SHALL be registered (glitch-free); tx=1 in IDLE.

Reset
REQ-022 While rst=0: tx=1, busy=0, sent=0, state=IDLE, last_key=8'h00, pending cleared, counters 0; so the driver's post-reset LEFT (0x34) is transmitted once.
REQ-023 Reset asserted mid-frame SHALL abort immediately (tx=1 asynchronously); no partial-frame resumption after release.

Configuration
REQ-024 Macro KEY_ECHO_CRLF_EN: when defined, each key byte SHALL be followed by two full 8N1 frames 0x0D then 0x0A, busy high throughout, pending checked only after 0x0A; when undefined, only the key byte is sent and SUFFIX state does not exist.
REQ-025 sent timing (REQ-020) SHALL be identical with and without KEY_ECHO_CRLF_EN.

Verification (CLKS_PER_BIT=4, macro undefined unless stated)
REQ-026 Release rst, key_in=0x34 -> one frame on tx: 0,0,0,1,0,1,1,0,0,1 (each bit 4 clk), sent pulse at clk 40, busy low after.
REQ-027 key_in 0x34 held 200 clk after first frame -> tx stays 1, no sent pulse.
REQ-028 key_in=0x38 then at clk 10 of its frame 0x36, at clk 20 0x32 -> frames 0x38 then 0x32 back-to-back, 0x36 never sent.
REQ-029 key_in=0x41 or 0x00 while idle -> no frame; subsequent 0x31 -> one frame 0x31.
REQ-030 rst low at clk 15 of a 0x39 frame -> tx=1 same cycle, busy=0; after release with key_in=0x39 -> full 0x39 frame resent.
REQ-031 KEY_ECHO_CRLF_EN defined, key_in=0x36 -> frames 0x36, 0x0D, 0x0A contiguous (120 clk), single sent pulse at clk 40.
